// File: rtl/minicpu_pkg.sv
// Shared definitions for the mini CPU front end: opcodes, instruction field
// positions, widths and the sign-magnitude immediate decoder.
package minicpu_pkg;

  localparam int REG_W   = 4;
  localparam int DATA_W  = 16;
  localparam int OPC_W   = 3;
  localparam int INSTR_W = 18;

  localparam logic [OPC_W-1:0] OP_LOAD    = 3'b000;
  localparam logic [OPC_W-1:0] OP_ADD     = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADDI    = 3'b010;
  localparam logic [OPC_W-1:0] OP_SUB     = 3'b011;
  localparam logic [OPC_W-1:0] OP_SUBI    = 3'b100;
  localparam logic [OPC_W-1:0] OP_MUL     = 3'b101;
  localparam logic [OPC_W-1:0] OP_CLEAR   = 3'b110;
  localparam logic [OPC_W-1:0] OP_DISPLAY = 3'b111;

  localparam int OPC_LSB   = 15;
  localparam int RD_LSB    = 11;
  localparam int RS1_LSB   = 7;
  localparam int RS2_LSB   = 3;
  localparam int IMM_SIGN  = 6;
  localparam int IMM_MAG_W = 6;

  typedef enum logic [2:0] {
    DB_ARMING,
    DB_RELEASED,
    DB_PRESS_WAIT,
    DB_PRESSED,
    DB_RELEASE_WAIT
  } db_state_t;

  // Sign-magnitude to two's complement; a negative zero folds to 0x0000.
  function automatic logic [DATA_W-1:0] decode_imm(input logic [IMM_SIGN:0] field);
    logic [DATA_W-1:0] mag;
    mag = {{(DATA_W-IMM_MAG_W){1'b0}}, field[IMM_MAG_W-1:0]};
    return field[IMM_SIGN] ? (~mag + 1'b1) : mag;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises the active-low pushbutton and emits one clk-wide press pulse
// per accepted press, after the level has been stable long enough.
//
// state           | meaning
// ----------------+-----------------------------------------------------------
// DB_ARMING       | after reset; wait for a stable release (no press possible)
// DB_RELEASED     | button stably up; any low starts a press qualification
// DB_PRESS_WAIT   | low seen; counting stable lows, a high is a bounce
// DB_PRESSED      | press accepted and reported; wait for the button to lift
// DB_RELEASE_WAIT | high seen; counting stable highs, a low returns to PRESSED
module button_debouncer
  import minicpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic enviar,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_1;
  logic             es;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // Synchroniser idles high so a button held through reset looks released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      es     <= 1'b1;
    end else begin
      sync_1 <= enviar;
      es     <= sync_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DB_ARMING;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    press     = 1'b0;
    unique case (state)
      DB_ARMING: begin
        if (!es) begin
          count_nxt = '0;
        end else if (count == CNT_MAX) begin
          state_nxt = DB_RELEASED;
          count_nxt = '0;
        end else begin
          count_nxt = count + CNT_ONE;
        end
      end
      DB_RELEASED: begin
        if (!es) begin
          state_nxt = DB_PRESS_WAIT;
          count_nxt = CNT_ONE;
        end
      end
      DB_PRESS_WAIT: begin
        if (es) begin
          state_nxt = DB_RELEASED;
          count_nxt = '0;
        end else if (count == CNT_MAX) begin
          state_nxt = DB_PRESSED;
          count_nxt = '0;
          press     = 1'b1;
        end else begin
          count_nxt = count + CNT_ONE;
        end
      end
      DB_PRESSED: begin
        if (es) begin
          state_nxt = DB_RELEASE_WAIT;
          count_nxt = CNT_ONE;
        end
      end
      DB_RELEASE_WAIT: begin
        if (!es) begin
          state_nxt = DB_PRESSED;
          count_nxt = '0;
        end else if (count == CNT_MAX) begin
          state_nxt = DB_RELEASED;
          count_nxt = '0;
        end else begin
          count_nxt = count + CNT_ONE;
        end
      end
      default: begin
        state_nxt = DB_ARMING;
        count_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/instr_capture.sv
// Front end of the mini CPU: latches the instruction switches on each clean
// press of "enviar", decodes the fields and offers them over valid/ready.
module instr_capture
  import minicpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] switches,
  input  logic               enviar,
  input  logic               cpu_ready,
  output logic               instr_valid,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [DATA_W-1:0]  imm,
  output logic               overrun
);

  logic press;
  logic xfer;
  logic slot_free;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .enviar (enviar),
    .press  (press)
  );

  assign xfer      = instr_valid & cpu_ready;
  // A word leaving this cycle frees the slot for a press arriving together.
  assign slot_free = ~instr_valid | cpu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      overrun     <= 1'b0;
      opcode      <= '0;
      rd          <= '0;
      rs1         <= '0;
      rs2         <= '0;
      imm         <= '0;
    end else if (press && slot_free) begin
      instr_valid <= 1'b1;
      opcode      <= switches[OPC_LSB +: OPC_W];
      rd          <= switches[RD_LSB +: REG_W];
      rs1         <= switches[RS1_LSB +: REG_W];
      rs2         <= switches[RS2_LSB +: REG_W];
      imm         <= decode_imm(switches[IMM_SIGN:0]);
    end else begin
      if (xfer) instr_valid <= 1'b0;
      if (press) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_capture.sv
// Randomised and directed checks of instr_capture against a run-length
// button model and a slot/handshake model of the capture register.
module tb_instr_capture;
  import minicpu_pkg::*;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] switches;
  logic        enviar;
  logic        cpu_ready;
  logic        instr_valid;
  logic [2:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [15:0] imm;
  logic        overrun;

  instr_capture #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .switches    (switches),
    .enviar      (enviar),
    .cpu_ready   (cpu_ready),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm         (imm),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  bit          m_valid;
  bit          m_ovr;
  logic [17:0] m_word;
  bit          m_pipe0;
  bit          m_pipe1;
  bit          m_down;
  int          m_run;
  bit          rand_ready = 0;

  function automatic logic [15:0] ref_imm(input logic [6:0] f);
    int v;
    v = int'(f[5:0]);
    if (f[6]) v = -v;
    return 16'(v);
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    bit          es;
    bit          press;
    logic [30:0] exp_f;
    if (rand_ready) cpu_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_ovr = 0; m_word = '0;
      m_pipe0 = 1; m_pipe1 = 1; m_down = 1; m_run = 0;
    end else begin
      es      = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = enviar;
      press   = 0;
      // The button changes level only after DB+1 consecutive opposite samples.
      if (es == m_down) m_run++;
      else m_run = 0;
      if (m_run == DB + 1) begin
        m_down = !m_down;
        m_run  = 0;
        press  = m_down;
      end
      if (press && (!m_valid || cpu_ready)) begin
        m_valid = 1;
        m_word  = switches;
      end else begin
        if (m_valid && cpu_ready) m_valid = 0;
        if (press) m_ovr = 1;
      end
    end
    #1;
    exp_f = {m_word[17:15], m_word[14:11], m_word[10:7], m_word[6:3], ref_imm(m_word[6:0])};
    chk_val("valid", instr_valid, m_valid);
    chk_val("overrun", overrun, m_ovr);
    chk_val("fields", {opcode, rd, rs1, rs2, imm}, exp_f);
  endtask

  task automatic hold(input logic level, input int n);
    enviar = level;
    repeat (n) tick();
  endtask

  task automatic press_clean(input logic [17:0] word, input int low, input int high);
    switches = word;
    hold(1'b0, low);
    hold(1'b1, high);
  endtask

  initial begin
    int first;
    int ones;
    logic [17:0] wa;
    logic [17:0] wb;

    rst = 1; enviar = 1; cpu_ready = 0; switches = '0;
    tick(); tick();
    chk_val("rst_valid", instr_valid, 0);
    chk_val("rst_fields", {opcode, rd, rs1, rs2, imm, overrun}, 0);
    rst = 0;
    hold(1'b1, 12);

    // clean press, ready: single-cycle valid 7 cycles after first low
    switches = {OP_ADDI, 4'd1, 4'd2, 7'b1000101};
    cpu_ready = 1; enviar = 0; first = -1; ones = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (instr_valid) begin
        ones++;
        if (first < 0) begin
          first = t;
          chk_val("t1_opcode", opcode, 2);
          chk_val("t1_rd", rd, 1);
          chk_val("t1_rs1", rs1, 2);
          chk_val("t1_rs2", rs2, 8);
          chk_val("t1_imm", imm, 16'hFFFB);
        end
      end
    end
    chk_val("t1_latency", first, 7);
    chk_val("t1_pulse_len", ones, 1);
    hold(1'b1, 12);

    // bounce: low 2, high 1, low 10
    switches = {OP_SUB, 4'd3, 4'd4, 4'd5, 3'd1};
    first = -1; ones = 0;
    for (int t = 1; t <= 13; t++) begin
      enviar = (t == 3);
      tick();
      if (instr_valid) begin
        ones++;
        if (first < 0) first = t;
      end
    end
    chk_val("t2_latency", first, 10);
    chk_val("t2_count", ones, 1);
    hold(1'b1, 12);

    // ready low: first word held, second dropped
    cpu_ready = 0;
    wa = {OP_MUL, 4'd7, 4'd8, 7'b0011111};
    wb = {OP_LOAD, 4'd9, 4'd10, 7'b1111111};
    press_clean(wa, 8, 12);
    press_clean(wb, 8, 12);
    chk_val("t3_valid", instr_valid, 1);
    chk_val("t3_opcode", opcode, 5);
    chk_val("t3_imm", imm, 16'h001F);
    chk_val("t3_overrun", overrun, 1);
    cpu_ready = 1; tick();
    chk_val("t3_xfer_valid", instr_valid, 0);
    chk_val("t3_overrun_sticky", overrun, 1);
    cpu_ready = 0;

    // ready rises in the same cycle as the second press
    press_clean(wa, 8, 12);
    switches = wb; enviar = 0;
    repeat (6) tick();
    cpu_ready = 1; tick();
    chk_val("t4_valid", instr_valid, 1);
    chk_val("t4_rd", rd, 9);
    chk_val("t4_imm", imm, 16'hFFC1);
    cpu_ready = 0;
    hold(1'b0, 1);
    hold(1'b1, 12);
    cpu_ready = 1; tick(); cpu_ready = 0;

    // button held through reset
    rst = 1; enviar = 0; tick(); rst = 0;
    ones = 0;
    for (int t = 0; t < 20; t++) begin tick(); if (instr_valid) ones++; end
    enviar = 1;
    for (int t = 0; t < 12; t++) begin tick(); if (instr_valid) ones++; end
    chk_val("t5_no_capture", ones, 0);
    press_clean({OP_DISPLAY, 4'd15, 4'd0, 7'b1000000}, 8, 12);
    chk_val("t5_valid", instr_valid, 1);
    chk_val("t5_neg_zero", imm, 16'h0000);
    chk_val("t5_overrun", overrun, 0);

    // reset while pending
    rst = 1; tick(); rst = 0;
    chk_val("t6_valid", instr_valid, 0);
    chk_val("t6_fields", {opcode, rd, rs1, rs2, imm, overrun}, 0);
    hold(1'b1, 12);

    // random words, bounces and ready patterns against the model
    rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      switches = 18'($urandom);
      for (int b = $urandom_range(0, 2); b > 0; b--) begin
        hold(1'b0, $urandom_range(1, 3));
        hold(1'b1, 1);
      end
      hold(1'b0, $urandom_range(6, 10));
      hold(1'b1, $urandom_range(8, 14));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_capture.md
Name: instr_capture

Overview:
- Front-end stage directly upstream of the mini CPU core.
- Debounces the raw active-low "enviar" pushbutton and latches the 18 instruction switches on each clean press.
- Decodes the latched word into opcode, register fields and a sign-extended immediate.
- Presents the result to the core over a valid/ready handshake, so the core runs entirely on clk.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles needed to accept a level change (10 ms at 50 MHz); legal range >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, never overridden.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- switches  in  18  instruction switches; quasi-static, not synchronised.
- enviar  in  1  raw pushbutton, asynchronous, active-low (0 = pressed).
- cpu_ready  in  1  core can accept an instruction this cycle.
- instr_valid  out  1  latched instruction available.
- opcode  out  3  switches[17:15] at capture.
- rd  out  4  switches[14:11] at capture.
- rs1  out  4  switches[10:7] at capture.
- rs2  out  4  switches[6:3] at capture.
- imm  out  16  two's-complement immediate decoded from switches[6:0] at capture.
- overrun  out  1  sticky flag: a press was dropped.

Behaviour:
- Reset values:
  - instr_valid = 0, overrun = 0.
  - opcode, rd, rs1, rs2 and imm are all 0.
  - Both synchroniser flops = 1, debounce counter = 0, debounce FSM = ARMING.
- Synchroniser: enviar passes through 2 flops; "es" is the second flop output.
- Debounce FSM states: ARMING, RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - ARMING: count cycles with es = 1; es = 0 clears the count. At DEBOUNCE_CYCLES consecutive highs go to RELEASED. A button held through reset never produces a press.
  - RELEASED: es = 0 -> PRESS_WAIT with count = 1.
  - PRESS_WAIT: es = 1 -> RELEASED, count cleared (bounce). es = 0 -> count++. When count reaches DEBOUNCE_CYCLES -> PRESSED, and a one-cycle internal "press" pulse is raised in the same transition.
  - PRESSED: es = 1 -> RELEASE_WAIT with count = 1.
  - RELEASE_WAIT: es = 0 -> PRESSED, count cleared. DEBOUNCE_CYCLES consecutive highs -> RELEASED.
  - Exactly one press pulse per accepted press, however long the button is held.
- Latency: enviar first sampled low at edge N (held low) -> instr_valid = 1 after edge N+DEBOUNCE_CYCLES+2, i.e. observable in cycle N+DEBOUNCE_CYCLES+3.
- Capture, on the press pulse when the slot is free (instr_valid = 0, or cpu_ready = 1 this cycle):
  - switches are registered into the output fields and instr_valid is set.
- Handshake:
  - Transfer happens on a cycle where instr_valid & cpu_ready.
  - After a transfer with no new press in that cycle, instr_valid = 0 next cycle.
  - Fields hold their values while instr_valid = 1 and no transfer occurs.
- Simultaneous transfer and press in the same cycle: the new word is captured, instr_valid stays 1 and the fields update.
- Press while instr_valid = 1 and cpu_ready = 0: the press is dropped, fields are unchanged, overrun is set to 1. overrun clears only on rst.
- Immediate decode:
  - switches[6] is the sign and switches[5:0] the magnitude (sign-magnitude).
  - imm = sign ? -{10'b0, mag} : {10'b0, mag}.
  - -0 decodes to 0x0000; range -63..+63.
  - rs2 and imm are always both driven, because their fields overlap; the core chooses which to use by opcode.
- rst asserted mid-debounce or while an instruction is pending:
  - Everything returns to the reset values on the next edge.
  - The pending instruction is discarded; the FSM re-enters ARMING.

Decomposition:
- Shared package minicpu_pkg holds:
  - opcode constants LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111;
  - field bit-position constants;
  - the register-index width (4) and data width (16).
- Sub-module button_debouncer contains the synchroniser, the 5-state FSM and the counter. It is parameterised by DEBOUNCE_CYCLES and outputs the press pulse. instr_capture instantiates it once and adds the capture register, handshake and decode.

Test Plan (bench DEBOUNCE_CYCLES=4):
- Reset, switches=18'b010_0001_0010_1000101 (ADDI, rd=1, rs1=2, imm field 1000101), clean press with cpu_ready=1 -> instr_valid is a single 1-cycle pulse 7 cycles after first low sample; opcode=2, rd=1, rs1=2, rs2=8, imm=0xFFFB (-5).
- Bounce: enviar low 2 cycles, high 1 cycle, low 10 cycles -> exactly one capture, timed from the second falling edge.
- cpu_ready=0, two separate clean presses -> first word held, second dropped, overrun=1; later cpu_ready=1 transfers the first word, overrun stays 1.
- cpu_ready rises in the same cycle as a second press pulse -> instr_valid stays 1 and the fields switch to the second word.
- Button held low across rst deassertion for 20 cycles, then released and pressed again -> no capture until the second press.
- Assert rst while instr_valid=1 -> next cycle instr_valid=0, all fields 0, overrun=0; imm for switches[6:0]=1000000 decodes to 0x0000.
